// File: rtl/mult_seq_if.sv
// Handshake bundle between the EXE stage and the sequential multiplier controller.
interface mult_seq_if;
  logic        mult_valid;
  logic        mult_ready;
  logic        mult_signed;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic        cancel;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] product;
  logic        busy;

  modport master (
    output mult_valid, mult_signed, mult_op1, mult_op2, cancel, res_ready,
    input  mult_ready, res_valid, product, busy
  );

  modport slave (
    input  mult_valid, mult_signed, mult_op1, mult_op2, cancel, res_ready,
    output mult_ready, res_valid, product, busy
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// Iterative shift-add MULT/MULTU sequencer: IDLE -> CALC -> SIGN -> DONE -> IDLE.
// Optional feature macro: MULT_EARLY_OUT_EN (finish CALC as soon as the multiplier is exhausted).
module mult_seq_ctrl #(
  parameter int BITS_PER_CYCLE = 1
) (
  input logic        clk,
  input logic        reset,
  mult_seq_if.slave  bus
);

  localparam int N     = 32 / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(N);

  generate
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)) begin : g_bpc_check
      $error("mult_seq_ctrl: BITS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               neg;
  logic [63:0]        mcand;
  logic [31:0]        mplier;
  logic [63:0]        acc;
  logic [63:0]        product_r;
  logic               accept;
  logic               last_iter;
  logic               skip;

  // Magnitude of an operand; 0x8000_0000 maps to unsigned 2^31, which is exact here.
  function automatic logic [31:0] abs_op(input logic [31:0] v, input logic sgn);
    logic signed [31:0] s;
    s = signed'(v);
    if (sgn && s < 0)
      return 32'(-s);
    return v;
  endfunction

  function automatic logic [63:0] partial(input logic [63:0] mc,
                                          input logic [BITS_PER_CYCLE-1:0] digit);
    logic [63:0] sum;
    sum = '0;
    for (int i = 0; i < BITS_PER_CYCLE; i++)
      if (digit[i])
        sum = sum + (mc << i);
    return sum;
  endfunction

  function automatic logic [63:0] sign_fix(input logic [63:0] a, input logic n);
    return n ? (~a + 64'd1) : a;
  endfunction

  assign accept    = (state == IDLE) && bus.mult_valid && !bus.cancel;
  assign last_iter = (cnt == CNT_W'(N - 1));

`ifdef MULT_EARLY_OUT_EN
  assign skip = (mplier == 32'd0);
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept)                 state_nxt = CALC;
      CALC: if (skip || last_iter)      state_nxt = SIGN;
      SIGN:                             state_nxt = DONE;
      DONE: if (bus.res_ready)          state_nxt = IDLE;
      default:                          state_nxt = IDLE;
    endcase
    if (bus.cancel)
      state_nxt = IDLE;
  end

  // Control-side registers: iteration count, sign flag and the held result.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      neg       <= 1'b0;
      product_r <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          cnt <= '0;
          neg <= bus.mult_signed & (bus.mult_op1[31] ^ bus.mult_op2[31]);
        end
        CALC: if (!skip) cnt <= cnt + CNT_W'(1);
        SIGN: if (!bus.cancel) product_r <= sign_fix(acc, neg);
        default: ;
      endcase
    end
  end

  // Shift-add datapath; contents only matter between accept and SIGN.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (accept) begin
        mcand  <= {32'd0, abs_op(bus.mult_op1, bus.mult_signed)};
        mplier <= abs_op(bus.mult_op2, bus.mult_signed);
        acc    <= '0;
      end
    end else if (state == CALC && !skip) begin
      acc    <= acc + partial(mcand, mplier[BITS_PER_CYCLE-1:0]);
      mcand  <= mcand << BITS_PER_CYCLE;
      mplier <= mplier >> BITS_PER_CYCLE;
    end
  end

  // A cancel in DONE withdraws the result in the same cycle so it cannot be consumed.
  assign bus.mult_ready = (state == IDLE);
  assign bus.res_valid  = (state == DONE) && !bus.cancel;
  assign bus.busy       = (state != IDLE);
  assign bus.product    = product_r;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed cases plus randomized operands against an arithmetic model.
module tb_mult_seq_ctrl #(
  parameter int BPC = 1
);
  localparam int N = 32 / BPC;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mult_seq_if bus();

  mult_seq_ctrl #(.BITS_PER_CYCLE(BPC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [63:0] last_prod;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_prod(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    if (s) begin
      sa = signed'(a);
      sb = signed'(b);
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  // Cycles from accept (cycle 0) to the first cycle with res_valid high.
  function automatic int model_lat(input logic [31:0] b, input logic s);
    longint v;
    int     bits;
    int     upd;
    v = s ? longint'(signed'(b)) : longint'(b);
    if (v < 0) v = -v;
    bits = 0;
    while (v > 0) begin
      bits++;
      v = v >> 1;
    end
    upd = (bits + BPC - 1) / BPC;
`ifdef MULT_EARLY_OUT_EN
    if (bits == 0) return 3;
    return (upd == N) ? N + 2 : upd + 3;
`else
    return (upd >= 0) ? N + 2 : N + 2;
`endif
  endfunction

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input int hold, input string tag);
    logic [63:0] exp_p;
    int          exp_l;
    int          lat;
    bit          busy_ok;
    exp_p = model_prod(a, b, s);
    exp_l = model_lat(b, s);
    @(negedge clk);
    chk1({tag, "_ready"}, bus.mult_ready, 1'b1);
    bus.mult_valid  = 1'b1;
    bus.mult_signed = s;
    bus.mult_op1    = a;
    bus.mult_op2    = b;
    bus.res_ready   = (hold == 0);
    @(posedge clk);
    #1;
    bus.mult_valid  = 1'b0;
    bus.mult_op1    = $urandom;
    bus.mult_op2    = $urandom;
    bus.mult_signed = 1'($urandom);
    lat = 0;
    busy_ok = 1'b1;
    do begin
      lat++;
      @(negedge clk);
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end while (bus.res_valid !== 1'b1 && lat < 200);
    chk({tag, "_latency"}, 64'(lat), 64'(exp_l));
    chk({tag, "_product"}, bus.product, exp_p);
    chk1({tag, "_busy"}, busy_ok, 1'b1);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk1({tag, "_hold_valid"}, bus.res_valid, 1'b1);
      chk({tag, "_hold_product"}, bus.product, exp_p);
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk1({tag, "_idle_ready"}, bus.mult_ready, 1'b1);
    chk1({tag, "_idle_valid"}, bus.res_valid, 1'b0);
    chk1({tag, "_idle_busy"}, bus.busy, 1'b0);
    bus.res_ready = 1'b0;
    last_prod = exp_p;
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'h8000_0000;
      3:       return 32'hFFFF_FFFF;
      4:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit quiet;
    reset           = 1'b1;
    bus.mult_valid  = 1'b0;
    bus.mult_signed = 1'b0;
    bus.mult_op1    = '0;
    bus.mult_op2    = '0;
    bus.cancel      = 1'b0;
    bus.res_ready   = 1'b0;
    last_prod       = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_ready", bus.mult_ready, 1'b1);
    chk1("rst_valid", bus.res_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk("rst_product", bus.product, 64'd0);
    reset = 1'b0;

    run_op(32'd3, 32'd4, 1'b0, 0, "mulu_3x4");
    run_op(32'hFFFF_FFFD, 32'd5, 1'b1, 0, "mul_m3x5");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 0, "mul_min_sq");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0, "mulu_max_sq");
    run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 3, "hold3");
    run_op(32'd7, 32'd0, 1'b0, 0, "mulu_7x0");
    run_op(32'd5, 32'd1, 1'b0, 0, "mulu_5x1");

    // cancel in CALC cycle 5
    @(negedge clk);
    bus.mult_valid  = 1'b1;
    bus.mult_signed = 1'b0;
    bus.mult_op1    = 32'h1234_5678;
    bus.mult_op2    = 32'h8000_0001;
    @(posedge clk);
    #1;
    bus.mult_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk1("cancel_busy_before", bus.busy, 1'b1);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    @(negedge clk);
    chk1("cancel_ready", bus.mult_ready, 1'b1);
    chk1("cancel_busy", bus.busy, 1'b0);
    chk("cancel_product", bus.product, last_prod);
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) quiet = 1'b0;
    end
    chk1("cancel_no_valid", quiet, 1'b1);

    // cancel together with an accept
    @(negedge clk);
    bus.mult_valid = 1'b1;
    bus.cancel     = 1'b1;
    @(posedge clk);
    #1;
    bus.mult_valid = 1'b0;
    bus.cancel     = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0 || bus.busy !== 1'b0) quiet = 1'b0;
    end
    chk1("cancel_accept_idle", quiet, 1'b1);

    // reset in CALC
    @(negedge clk);
    bus.mult_valid = 1'b1;
    bus.mult_op1   = 32'hDEAD_BEEF;
    bus.mult_op2   = 32'hFFFF_0001;
    @(posedge clk);
    #1;
    bus.mult_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk1("midrst_ready", bus.mult_ready, 1'b1);
    chk1("midrst_valid", bus.res_valid, 1'b0);
    chk1("midrst_busy", bus.busy, 1'b0);
    chk("midrst_product", bus.product, 64'd0);
    last_prod = '0;

    for (int i = 0; i < 24; i++)
      run_op(pick_op(), pick_op(), 1'($urandom), $urandom_range(0, 2), "rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
